// File: rtl/grf_mp.sv
// grf_mp: multi-read, dual-write register file with same-cycle forwarding and a busy scoreboard
module grf_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter logic [DATA_W-1:0] INIT = '0,
  parameter bit TRACE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          a0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic [31:0]                pc0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          a1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic [31:0]                pc1,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic                       flush,
  output logic [NUM_RD-1:0]          busy,
  output logic [(1<<ADDR_W)-1:0]     busy_vec
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  always_comb begin
    mem_d = mem_q;
    if (we0) mem_d[a0] = wd0;
    if (we1) mem_d[a1] = wd1;
    mem_d[0] = '0;
  end
  // flush squashes the issuer; a new issue supersedes a same-cycle writeback
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < DEPTH; r++)
      busy_d[r] = flush ? 1'b0
                : (iss_en && iss_addr == ADDR_W'(r)) ? 1'b1
                : ((we0 && a0 == ADDR_W'(r)) || (we1 && a1 == ADDR_W'(r))) ? 1'b0
                : busy_q[r];
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= (i == 0) ? '0 : INIT;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  assign busy_vec = busy_q;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] r;
    logic h0, h1;
    assign r  = ra[k*ADDR_W +: ADDR_W];
    assign h0 = we0 && a0 == r;
    assign h1 = we1 && a1 == r;
    assign rd[k*DATA_W +: DATA_W] = (r == '0) ? '0 : h1 ? wd1 : h0 ? wd0 : mem_q[r];
    assign busy[k] = (r != '0) && busy_q[r] && !(h0 || h1);
  end
  always @(posedge clk)
    if (TRACE && !reset) begin
      if (we0) $display("%d@%h: $%d <= %h", $time, pc0, a0, wd0);
      if (we1) $display("%d@%h: $%d <= %h", $time, pc1, a1, wd1);
    end
endmodule

// File: tb/tb_grf_mp.sv
// tb_grf_mp: scoreboard-driven checks of grf_mp reads, writes, forwarding and busy tracking
module tb_grf_mp;
  logic clk = 0;
  logic reset = 0;
  logic we0 = 0, we1 = 0, iss_en = 0, flush = 0;
  logic [4:0] a0 = 0, a1 = 0, iss_addr = 0, ra0 = 0, ra1 = 0;
  logic [31:0] wd0 = 0, wd1 = 0, pc0 = 0, pc1 = 0;
  logic [63:0] rd;
  logic [1:0] busy;
  logic [31:0] busy_vec;
  logic [31:0] exp_q [$];
  logic [31:0] exp, m [32];
  int checks = 0, errors = 0;

  grf_mp dut (.clk(clk), .reset(reset), .we0(we0), .a0(a0), .wd0(wd0), .pc0(pc0),
              .we1(we1), .a1(a1), .wd1(wd1), .pc1(pc1), .ra({ra1, ra0}), .rd(rd),
              .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy(busy),
              .busy_vec(busy_vec));

  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_en = 0; flush = 0;
  endtask

  task automatic test_reset();
    #1 reset = 1;
    tick();
    tick();
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(31 - i);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      #1;
      checks++; exp = exp_q.pop_front();
      if (rd[31:0] !== exp) begin errors++; $display("FAIL reset_rd0 a=%0d got %h want %h", i, rd[31:0], exp); end
      checks++; exp = exp_q.pop_front();
      if (rd[63:32] !== exp) begin errors++; $display("FAIL reset_rd1 a=%0d got %h want %h", 31 - i, rd[63:32], exp); end
    end
    checks++;
    if (busy_vec !== 32'h0 || busy !== 2'b0) begin errors++; $display("FAIL reset_busy got %h/%b want 0/0", busy_vec, busy); end
    we0 = 1; a0 = 7; wd0 = 32'h0000_00AA; iss_en = 1; iss_addr = 10;
    tick();
    idle();
    ra0 = 7; exp_q.push_back(32'h0000_00AA);
    #1;
    checks++; exp = exp_q.pop_front();
    if (rd[31:0] !== exp) begin errors++; $display("FAIL pre_reset_write got %h want %h", rd[31:0], exp); end
    checks++;
    if (busy_vec !== 32'h0000_0400) begin errors++; $display("FAIL pre_reset_busy got %h want %h", busy_vec, 32'h400); end
    #1 reset = 1;
    exp_q.push_back(32'h0);
    #1;
    checks++; exp = exp_q.pop_front();
    if (rd[31:0] !== exp) begin errors++; $display("FAIL async_reset_rd got %h want %h", rd[31:0], exp); end
    checks++;
    if (busy_vec !== 32'h0) begin errors++; $display("FAIL async_reset_busy got %h want 0", busy_vec); end
    tick();
    reset = 0;
  endtask

  task automatic test_dual_write();
    we0 = 1; a0 = 5; wd0 = 32'h1111_1111; pc0 = 32'h100;
    we1 = 1; a1 = 5; wd1 = 32'h2222_2222; pc1 = 32'h104;
    ra0 = 5; exp_q.push_back(32'h2222_2222);
    #3;
    checks++; exp = exp_q.pop_front();
    if (rd[31:0] !== exp) begin errors++; $display("FAIL dual_fwd got %h want %h", rd[31:0], exp); end
    tick();
    idle();
    exp_q.push_back(32'h2222_2222);
    #1;
    checks++; exp = exp_q.pop_front();
    if (rd[31:0] !== exp) begin errors++; $display("FAIL dual_stored got %h want %h", rd[31:0], exp); end
  endtask

  task automatic test_reg0();
    we0 = 1; a0 = 0; wd0 = 32'hDEAD_BEEF; pc0 = 32'h200;
    ra0 = 0; ra1 = 0; exp_q.push_back(32'h0);
    #3;
    checks++; exp = exp_q.pop_front();
    if (rd[31:0] !== exp) begin errors++; $display("FAIL r0_fwd got %h want %h", rd[31:0], exp); end
    tick();
    idle();
    iss_en = 1; iss_addr = 0; exp_q.push_back(32'h0);
    #1;
    checks++; exp = exp_q.pop_front();
    if (rd[63:32] !== exp) begin errors++; $display("FAIL r0_stored got %h want %h", rd[63:32], exp); end
    tick();
    idle();
    checks++;
    if (busy_vec !== 32'h0 || busy !== 2'b0) begin errors++; $display("FAIL r0_busy got %h/%b want 0/0", busy_vec, busy); end
  endtask

  task automatic test_scoreboard();
    iss_en = 1; iss_addr = 8;
    tick();
    idle();
    ra0 = 8;
    #1;
    checks++;
    if (busy_vec[8] !== 1'b1 || busy[0] !== 1'b1) begin errors++; $display("FAIL issue_busy got %b/%b want 1/1", busy_vec[8], busy[0]); end
    tick();
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL issue_hold got %b want 1", busy[0]); end
    tick();
    we1 = 1; a1 = 8; wd1 = 32'h0000_00AB; pc1 = 32'h300;
    exp_q.push_back(32'h0000_00AB);
    #1;
    checks++; exp = exp_q.pop_front();
    if (rd[31:0] !== exp || busy[0] !== 1'b0) begin errors++; $display("FAIL wb_fwd got %h/%b want %h/0", rd[31:0], busy[0], exp); end
    tick();
    idle();
    #1;
    checks++;
    if (busy_vec[8] !== 1'b0) begin errors++; $display("FAIL wb_clear got %b want 0", busy_vec[8]); end
  endtask

  task automatic test_issue_vs_write();
    iss_en = 1; iss_addr = 9; we0 = 1; a0 = 9; wd0 = 32'h99; pc0 = 32'h400;
    tick();
    idle();
    ra1 = 9;
    #1;
    checks++;
    if (busy_vec[9] !== 1'b1 || busy[1] !== 1'b1) begin errors++; $display("FAIL issue_beats_clear got %b/%b want 1/1", busy_vec[9], busy[1]); end
    we0 = 1; a0 = 9; wd0 = 32'h9A;
    tick();
    idle();
  endtask

  task automatic test_flush();
    iss_en = 1; iss_addr = 4;
    tick();
    iss_addr = 6;
    tick();
    idle();
    checks++;
    if (busy_vec !== 32'h0000_0050) begin errors++; $display("FAIL flush_pre got %h want %h", busy_vec, 32'h50); end
    iss_en = 1; iss_addr = 3; flush = 1; we0 = 1; a0 = 4; wd0 = 32'h44; pc0 = 32'h500;
    tick();
    idle();
    ra0 = 4; exp_q.push_back(32'h44);
    #1;
    checks++;
    if (busy_vec !== 32'h0) begin errors++; $display("FAIL flush_clear got %h want 0", busy_vec); end
    checks++; exp = exp_q.pop_front();
    if (rd[31:0] !== exp) begin errors++; $display("FAIL flush_write got %h want %h", rd[31:0], exp); end
  endtask

  task automatic test_back_to_back();
    #1 reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    for (int n = 0; n < 60; n++) begin
      we0 = 1'($urandom); a0 = 5'($urandom); wd0 = $urandom; pc0 = 32'(n);
      we1 = 1'($urandom); a1 = (n % 4 == 0) ? a0 : 5'($urandom); wd1 = $urandom; pc1 = 32'(n);
      ra0 = (n % 3 == 0) ? a1 : 5'($urandom); ra1 = (n % 5 == 0) ? a0 : 5'($urandom);
      exp_q.push_back(ra0 == 0 ? 32'h0 : (we1 && a1 == ra0) ? wd1 : (we0 && a0 == ra0) ? wd0 : m[ra0]);
      exp_q.push_back(ra1 == 0 ? 32'h0 : (we1 && a1 == ra1) ? wd1 : (we0 && a0 == ra1) ? wd0 : m[ra1]);
      #2;
      checks++; exp = exp_q.pop_front();
      if (rd[31:0] !== exp) begin errors++; $display("FAIL b2b_rd0 n=%0d got %h want %h", n, rd[31:0], exp); end
      checks++; exp = exp_q.pop_front();
      if (rd[63:32] !== exp) begin errors++; $display("FAIL b2b_rd1 n=%0d got %h want %h", n, rd[63:32], exp); end
      tick();
      if (we0 && a0 != 0) m[a0] = wd0;
      if (we1 && a1 != 0) m[a1] = wd1;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_reg0();
    test_scoreboard();
    test_issue_vs_write();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
